// File: rtl/sdram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
// Shared definitions for the SDRAM port arbiter slice: arbiter state
// encoding, default parameter values and width helper functions.
// No ports (package).
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

    localparam int DEF_NUM_PORTS = 2;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ADDR_W    = 23;
    localparam int DEF_BURST_LEN = 8;
    localparam int DEF_TIMEOUT   = 64;

    // Wishbone byte addresses are always 32 bits wide per port
    localparam int WB_ADR_W      = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2
    } arb_state_t;

    // Width of a counter that must hold every value 0..burst_len
    function automatic int beat_cnt_w(input int burst_len);
        return $clog2(burst_len + 1);
    endfunction

    // Width of a port index; never narrower than one bit
    function automatic int idx_w(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/sdram_rr_picker.sv
// -----------------------------------------------------------------------------
// sdram_rr_picker
// Combinational round-robin selector. Starting at rr_ptr and walking upward
// (wrapping past the last port), the first requesting port wins.
//
// Ports:
//   req       in   NUM_PORTS  request vector (one bit per port)
//   rr_ptr    in   IDX_W      index of the highest-priority port this round
//   grant     out  NUM_PORTS  one-hot winner (all zero when nobody requests)
//   grant_idx out  IDX_W      binary index of the winner
//   any_req   out  1          at least one port is requesting
// -----------------------------------------------------------------------------
module sdram_rr_picker
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int IDX_W     = idx_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 any_req
);

    logic             found;
    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk the ports in priority order starting at rr_ptr; the found flag
    // makes the first hit sticky so later candidates cannot overwrite it.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand     = (int'(rr_ptr) + i) % NUM_PORTS;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
// Round-robin arbiter that shares one SDRAM controller request port between
// NUM_PORTS Wishbone masters. A port requests with cyc&stb; the winner is
// registered into grant_o, its request is presented to the controller until
// accepted, and read beats are passed straight back to the granted port.
//
// Optional feature: define SDRAM_ARB_TIMEOUT_EN to add a read-wait watchdog
// that raises wbs_err_o for the granted port after TIMEOUT beat-less cycles.
// Without it wbs_err_o is constant zero and reads wait indefinitely.
//
// Ports:
//   clk, rst           in   clock, synchronous active-high reset
//   wbs_cyc_i/stb_i    in   per-port cycle and strobe
//   wbs_we_i           in   per-port write enable
//   burst_i            in   per-port burst-read request (BURST_LEN beats)
//   wbs_sel_i          in   per-port byte selects, port p at slice p
//   wbs_adr_i          in   per-port 32-bit byte address (low ADDR_W used)
//   wbs_dat_i          in   per-port write data
//   wbs_ack_o          out  per-port ack, at most one bit high
//   wbs_err_o          out  per-port watchdog error pulse
//   grant_o            out  one-hot current grant
//   wbs_dat_o          out  shared read data, valid with the ack
//   ctrl_addr_o        out  controller word address
//   ctrl_wdata_o       out  controller write data
//   ctrl_mask_o        out  controller byte mask (sel on writes, 0 on reads)
//   ctrl_rw_o          out  1 = write
//   ctrl_burst_o       out  burst read request
//   ctrl_in_valid_o    out  request strobe
//   ctrl_busy_i        in   controller cannot accept a request this cycle
//   ctrl_out_valid_i   in   read beat valid
//   ctrl_rdata_i       in   read beat data
// -----------------------------------------------------------------------------
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          wbs_cyc_i,
    input  logic [NUM_PORTS-1:0]          wbs_stb_i,
    input  logic [NUM_PORTS-1:0]          wbs_we_i,
    input  logic [NUM_PORTS-1:0]          burst_i,
    input  logic [NUM_PORTS*DATA_W/8-1:0] wbs_sel_i,
    input  logic [NUM_PORTS*WB_ADR_W-1:0] wbs_adr_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   wbs_dat_i,
    output logic [NUM_PORTS-1:0]          wbs_ack_o,
    output logic [NUM_PORTS-1:0]          wbs_err_o,
    output logic [NUM_PORTS-1:0]          grant_o,
    output logic [DATA_W-1:0]             wbs_dat_o,
    output logic [ADDR_W-1:0]             ctrl_addr_o,
    output logic [DATA_W-1:0]             ctrl_wdata_o,
    output logic [DATA_W/8-1:0]           ctrl_mask_o,
    output logic                          ctrl_rw_o,
    output logic                          ctrl_burst_o,
    output logic                          ctrl_in_valid_o,
    input  logic                          ctrl_busy_i,
    input  logic                          ctrl_out_valid_i,
    input  logic [DATA_W-1:0]             ctrl_rdata_i
);

    localparam int SEL_W = DATA_W / 8;
    localparam int IDX_W = idx_w(NUM_PORTS);
    localparam int CNT_W = beat_cnt_w(BURST_LEN);

    arb_state_t state_q;
    arb_state_t state_d;

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 any_req;

    logic [NUM_PORTS-1:0] grant_q;
    logic [IDX_W-1:0]     g_idx;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     next_ptr;
    logic [CNT_W-1:0]     beat_cnt;

    logic                 g_we;
    logic                 g_burst;
    logic                 g_cyc;
    logic [ADDR_W-1:0]    g_adr;
    logic [DATA_W-1:0]    g_dat;
    logic [SEL_W-1:0]     g_sel;

    logic                 accept;
    logic                 beat_last;
    logic                 done;
    logic                 timeout_hit;
    logic                 unused_adr_bits;

    assign req = wbs_cyc_i & wbs_stb_i;

    sdram_rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any_req   (any_req)
    );

    // Fields of the currently granted port, selected by the registered index
    // so the controller sees a stable request for the whole ISSUE phase.
    always_comb begin
        g_we    = wbs_we_i[g_idx];
        g_burst = burst_i[g_idx];
        g_cyc   = wbs_cyc_i[g_idx];
        g_adr   = wbs_adr_i[int'(g_idx)*WB_ADR_W +: ADDR_W];
        g_dat   = wbs_dat_i[int'(g_idx)*DATA_W +: DATA_W];
        g_sel   = wbs_sel_i[int'(g_idx)*SEL_W +: SEL_W];
    end

    // Only the low ADDR_W bits of each byte address reach the controller
    assign unused_adr_bits = ^wbs_adr_i;

    assign next_ptr  = (int'(g_idx) == NUM_PORTS - 1) ? '0 : g_idx + IDX_W'(1);
    assign accept    = (state_q == ST_ISSUE) && !ctrl_busy_i;
    assign beat_last = ctrl_out_valid_i && (beat_cnt == CNT_W'(1));

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int WD_W = beat_cnt_w(TIMEOUT);

    logic [WD_W-1:0] wd_cnt;

    // The watchdog fires on the TIMEOUT-th consecutive RD_WAIT cycle that
    // carries no beat; a beat arriving on that cycle still wins.
    assign timeout_hit = (state_q == ST_RD_WAIT) && !ctrl_out_valid_i
                         && (wd_cnt == WD_W'(TIMEOUT - 1));

    // Count beat-less RD_WAIT cycles; any beat or leaving RD_WAIT restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state_q != ST_RD_WAIT || ctrl_out_valid_i || timeout_hit) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a write finishes on acceptance, a read finishes on
    // its last beat (or on a watchdog timeout when that feature is built in).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (accept) begin
                    state_d = g_we ? ST_IDLE : ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (beat_last || timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign done = (state_q != ST_IDLE) && (state_d == ST_IDLE);

    // Grant, round-robin pointer and beat counter. The grant is latched from
    // the picker in IDLE and cleared, with the pointer moving past the
    // finished port, on the cycle a transaction completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q  <= '0;
            g_idx    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            if (state_q == ST_IDLE && any_req) begin
                grant_q <= pick_grant;
                g_idx   <= pick_idx;
            end
            if (accept && !g_we) begin
                beat_cnt <= g_burst ? CNT_W'(BURST_LEN) : CNT_W'(1);
            end else if (state_q == ST_RD_WAIT && ctrl_out_valid_i) begin
                beat_cnt <= beat_cnt - CNT_W'(1);
            end
            if (done) begin
                grant_q  <= '0;
                rr_ptr   <= next_ptr;
                beat_cnt <= '0;
            end
        end
    end

    assign grant_o = grant_q;

    // Outputs. The controller request is only driven during ISSUE. Write acks
    // and read beats are combinational so the master sees them in the same
    // cycle; beats for a port that has dropped cyc are swallowed silently.
    always_comb begin
        wbs_ack_o       = '0;
        wbs_err_o       = '0;
        wbs_dat_o       = '0;
        ctrl_addr_o     = '0;
        ctrl_wdata_o    = '0;
        ctrl_mask_o     = '0;
        ctrl_rw_o       = 1'b0;
        ctrl_burst_o    = 1'b0;
        ctrl_in_valid_o = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                ctrl_in_valid_o = 1'b1;
                ctrl_addr_o     = g_adr;
                ctrl_wdata_o    = g_dat;
                ctrl_mask_o     = g_we ? g_sel : '0;
                ctrl_rw_o       = g_we;
                ctrl_burst_o    = !g_we && g_burst;
                if (accept && g_we) begin
                    wbs_ack_o[g_idx] = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (ctrl_out_valid_i) begin
                    wbs_dat_o = ctrl_rdata_i;
                    if (g_cyc) begin
                        wbs_ack_o[g_idx] = 1'b1;
                    end
                end
                if (timeout_hit) begin
                    wbs_err_o[g_idx] = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2: Wishbone master ports arbitrated; legal range 2..8.
REQ-002 Parameter DATA_W, default 32: data width; multiple of 8.
REQ-003 Parameter ADDR_W, default 23: controller word address width; taken from wbs_adr_i[ADDR_W-1:0] per port.
REQ-004 Parameter BURST_LEN, default 8: read beats per burst request; power of 2, range 2..16.
REQ-005 Parameter TIMEOUT, default 64: read-wait watchdog limit in cycles; used only under SDRAM_ARB_TIMEOUT_EN.
REQ-006 Clock and reset: clk, rst; reset is synchronous, active-high.
REQ-007 clk  in  1  block clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 wbs_cyc_i, wbs_stb_i, wbs_we_i, burst_i  in  NUM_PORTS each  per-port cycle, strobe, write, burst-read request.
REQ-010 wbs_sel_i  in  NUM_PORTS*DATA_W/8  per-port byte selects; port p at slice p.
REQ-011 wbs_adr_i  in  NUM_PORTS*32  per-port byte address.
REQ-012 wbs_dat_i  in  NUM_PORTS*DATA_W  per-port write data.
REQ-013 wbs_ack_o, wbs_err_o, grant_o  out  NUM_PORTS each  per-port ack, error, one-hot current grant.
REQ-014 wbs_dat_o  out  DATA_W  read data, shared, valid with the granted port's ack.
REQ-015 ctrl_addr_o, ctrl_wdata_o, ctrl_mask_o  out  ADDR_W, DATA_W, DATA_W/8  controller address, write data, byte mask.
REQ-016 ctrl_rw_o, ctrl_burst_o, ctrl_in_valid_o  out  1 each  write=1, burst read, request strobe.
REQ-017 ctrl_busy_i, ctrl_out_valid_i  in  1 each  controller busy, read beat valid; ctrl_rdata_i  in  DATA_W  read beat data.

Function
REQ-018 States IDLE, ISSUE, RD_WAIT; a port requests when cyc&stb both high.
REQ-019 IDLE: any request -> register round-robin winner (search from rr_ptr upward, wrapping) into grant_o, go ISSUE next cycle; no request -> stay.
REQ-020 ISSUE: ctrl_in_valid_o=1 with granted port's addr/data/mask/we/burst; request accepted on the cycle ctrl_in_valid_o=1 and ctrl_busy_i=0; held otherwise.
REQ-021 Write accept: wbs_ack_o[g] pulses that same cycle; ctrl_mask_o = sel for writes, 0 for reads; go IDLE.
REQ-022 Read accept: beat counter loads BURST_LEN if burst_i[g] else 1; go RD_WAIT.
REQ-023 RD_WAIT: each ctrl_out_valid_i -> wbs_dat_o=ctrl_rdata_i, wbs_ack_o[g] pulse same cycle (combinational pass), counter decrements; last beat -> IDLE.
REQ-024 Granted port drops cyc during RD_WAIT: remaining beats consumed without ack; state still completes all beats.
REQ-025 On return to IDLE, rr_ptr = g+1 modulo NUM_PORTS; grant_o clears.
REQ-026 Minimum latency: request at cycle n, grant n+1, write ack n+1 if ctrl_busy_i=0.
REQ-027 ctrl_out_valid_i outside RD_WAIT ignored; no ack generated.
REQ-028 Ack only to granted port; never more than one wbs_ack_o bit high.

Reset
REQ-029 rst: state IDLE, rr_ptr 0, grant_o 0, counter 0, watchdog 0, all acks/errs 0, ctrl_in_valid_o 0, wbs_dat_o 0.
REQ-030 Reset mid-transaction aborts it; no ack or err issued for it afterward.

Configuration
REQ-031 Macro SDRAM_ARB_TIMEOUT_EN defined: watchdog counts RD_WAIT cycles since last beat; at TIMEOUT, wbs_err_o[g] pulses one cycle, go IDLE, rr_ptr advances.
REQ-032 Macro undefined: no watchdog logic; wbs_err_o tied 0; RD_WAIT waits indefinitely.

Structure
REQ-033 Shared package sdram_arb_pkg: state enum, default parameter constants, beat-counter width function clog2(BURST_LEN+1).
REQ-034 Sub-module sdram_rr_picker: combinational one-hot round-robin select from request vector and rr_ptr.

Verification
REQ-035 Port0 write adr 0x10, dat 0xA5A5A5A5, busy=0 -> ctrl_addr_o=0x4 word? no: ctrl_addr_o=0x10, ctrl_rw_o=1, ack[0] at grant cycle.
REQ-036 Ports 0,1 request every cycle, 4 single writes each -> grants alternate 0,1,0,1..., no port starved.
REQ-037 Port1 burst read, controller returns 8 beats 0..7 with gaps -> 8 acks on port1 with data 0..7, then IDLE.
REQ-038 ctrl_busy_i high 5 cycles during ISSUE -> ctrl_in_valid_o held 5 cycles, single accept, single ack.
REQ-039 Port0 drops cyc after 3 of 8 beats -> 3 acks only, arbiter returns IDLE after beat 8, port1 then granted.
REQ-040 SDRAM_ARB_TIMEOUT_EN, TIMEOUT=64, no beats returned -> wbs_err_o[g] at cycle 64 of RD_WAIT; rst mid-RD_WAIT -> all outputs 0 next cycle.
